// File: rtl/dp_regfile_pkg.sv
// dp_regfile_pkg: shared export FSM states and the masked bit-merge helper
package dp_regfile_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {IDLE, HOLD} state_t;

    function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0] old,
                                                input logic [MAX_W-1:0] data,
                                                input logic [MAX_W-1:0] mask);
        return (data & mask) | (old & ~mask);
    endfunction

endpackage

// File: rtl/dp_regfile_rr_pick.sv
// dp_regfile_rr_pick: combinational round-robin first-set finder starting at a pointer
module dp_regfile_rr_pick
    import dp_regfile_pkg::*;
#(
    parameter int NREGS = 16,
    localparam int IW = $clog2(NREGS)
) (
    input  logic [NREGS-1:0] req,
    input  logic [IW-1:0]    start,
    output logic             found,
    output logic [IW-1:0]    idx
);

    int j;

    // scan NREGS positions from start with wrap, first set request wins
    always_comb begin
        found = 1'b0;
        idx = '0;
        j = 0;
        for (int i = 0; i < NREGS; i++) begin
            j = int'(start) + i;
            j = (j >= NREGS) ? j - NREGS : j;
            if (!found && req[j]) begin
                found = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dp_regfile.sv
// dp_regfile: dual-writer masked register file with change-export stream (option: DP_REGFILE_CHANGE_ONLY_EN)
module dp_regfile
    import dp_regfile_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               NREGS       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] RESET_MASK  = '1,
    localparam int              IW          = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [IW-1:0]    a_idx,
    input  logic [WIDTH-1:0] a_mask,
    input  logic [WIDTH-1:0] a_data,
    input  logic [IW-1:0]    b_idx,
    input  logic [WIDTH-1:0] b_mask,
    input  logic [WIDTH-1:0] b_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_idx,
    output logic [WIDTH-1:0] out_value
);

    logic [WIDTH-1:0] mem [NREGS];
    logic [WIDTH-1:0] nxt [NREGS];
    logic [WIDTH-1:0] am  [NREGS];
    logic [WIDTH-1:0] bm  [NREGS];
    logic [NREGS-1:0] dirty, wr, clr;
    logic [IW-1:0]    ptr, sel;
    logic             found, take;
    state_t           state;

    function automatic logic [WIDTH-1:0] mw(input logic [WIDTH-1:0] o,
                                            input logic [WIDTH-1:0] d,
                                            input logic [WIDTH-1:0] k);
        return WIDTH'(merge(MAX_W'(o), MAX_W'(d), MAX_W'(k)));
    endfunction

    dp_regfile_rr_pick #(.NREGS(NREGS)) u_pick (
        .req   (dirty),
        .start (ptr),
        .found (found),
        .idx   (sel)
    );

    // per-entry merge of A then B overlay; out-of-range indices match no entry
    always_comb begin
        for (int e = 0; e < NREGS; e++) begin
            am[e] = (a_idx == IW'(e)) ? a_mask : '0;
            bm[e] = (b_idx == IW'(e)) ? b_mask : '0;
            nxt[e] = mw(mw(mem[e], a_data, am[e]), b_data, bm[e]);
`ifdef DP_REGFILE_CHANGE_ONLY_EN
            wr[e] = (|(am[e] | bm[e])) && (nxt[e] != mem[e]);
`else
            wr[e] = |(am[e] | bm[e]);
`endif
        end
    end

    // a new export may start whenever idle or the held one is being accepted
    always_comb begin
        take = (state == IDLE) || out_ready;
        clr = (take && found) ? (NREGS'(1) << sel) : '0;
    end

    // storage, read port, dirty tracking and export FSM
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int e = 0; e < NREGS; e++)
                mem[e] <= (RESET_VALUE & RESET_MASK) | (mem[e] & ~RESET_MASK);
            rd_data   <= '0;
            dirty     <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_value <= '0;
            state     <= IDLE;
        end else begin
            for (int e = 0; e < NREGS; e++)
                mem[e] <= nxt[e];
            rd_data <= ({1'b0, rd_idx} < (IW+1)'(NREGS)) ? mem[rd_idx] : '0;
            dirty   <= (dirty & ~clr) | wr;
            if (take) begin
                if (found) begin
                    out_idx   <= sel;
                    out_value <= mem[sel];
                    ptr       <= (sel == IW'(NREGS-1)) ? '0 : sel + 1'b1;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end else begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dp_regfile.sv
// tb_dp_regfile: directed scoreboard bench for dp_regfile
module tb_dp_regfile;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] a_idx, b_idx, rd_idx, out_idx;
    logic [7:0] a_mask, a_data, b_mask, b_data, rd_data, out_value;
    logic       out_valid, out_ready;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dp_regfile #(
        .WIDTH       (8),
        .NREGS       (16),
        .RESET_VALUE (8'hA5),
        .RESET_MASK  (8'hF0)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .a_idx     (a_idx),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .b_idx     (b_idx),
        .b_mask    (b_mask),
        .b_data    (b_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_value (out_value)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick;
        exp_t e;
        if (nrst && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_export: observed idx %0h val %0h expected none", out_idx, out_value);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("export_idx", 32'(out_idx), 32'(e.idx));
                chk("export_val", 32'(out_value), 32'(e.val));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [3:0] i, input logic [7:0] m, input logic [7:0] d);
        a_idx = i; a_mask = m; a_data = d;
    endtask

    task automatic wr_b(input logic [3:0] i, input logic [7:0] m, input logic [7:0] d);
        b_idx = i; b_mask = m; b_data = d;
    endtask

    task automatic idle_ports;
        a_mask = 8'h00; b_mask = 8'h00;
    endtask

    initial begin
        nrst = 1'b0; out_ready = 1'b1; rd_idx = 4'd0;
        wr_a(4'd0, 8'h00, 8'h00);
        wr_b(4'd0, 8'h00, 8'h00);
        tick(); tick();
        nrst = 1'b1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);

        // entry 1 <= 3C, then masked reset gives AC
        wr_a(4'd1, 8'hFF, 8'h3C);
        exp_q.push_back('{4'd1, 8'h3C});
        tick(); idle_ports();
        chk("latency_t1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("latency_t2_valid", 32'(out_valid), 32'd1);
        tick();
        chk("single_export_1", 32'(out_valid), 32'd0);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        chk("reset_valid_after", 32'(out_valid), 32'd0);
        rd_idx = 4'd1;
        tick();
        chk("masked_reset_rd", 32'(rd_data), 32'hAC);

        // A and B on the same entry: B overrides low nibble
        wr_a(4'd3, 8'hFF, 8'h11);
        wr_b(4'd3, 8'h0F, 8'h22);
        exp_q.push_back('{4'd3, 8'h12});
        tick(); idle_ports();
        chk("merge_t1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("merge_t2_valid", 32'(out_valid), 32'd1);
        rd_idx = 4'd3;
        tick();
        chk("merge_single", 32'(out_valid), 32'd0);
        chk("merge_rd", 32'(rd_data), 32'h12);

        // move scan pointer to 8 by exporting entry 7
        wr_a(4'd7, 8'hFF, 8'h07);
        exp_q.push_back('{4'd7, 8'h07});
        tick(); idle_ports();
        tick(); tick();
        chk("ptr_setup_idle", 32'(out_valid), 32'd0);

        // round robin from 8: 14, then wrap to 2, then 7, back-to-back
        wr_a(4'd14, 8'hFF, 8'hE1);
        wr_b(4'd2, 8'hFF, 8'h21);
        exp_q.push_back('{4'd14, 8'hE1});
        exp_q.push_back('{4'd2, 8'h21});
        tick(); idle_ports();
        wr_a(4'd7, 8'hFF, 8'h77);
        exp_q.push_back('{4'd7, 8'h77});
        tick(); idle_ports();
        chk("rr_first_valid", 32'(out_valid), 32'd1);
        chk("rr_first_idx", 32'(out_idx), 32'd14);
        tick();
        chk("rr_second_valid", 32'(out_valid), 32'd1);
        chk("rr_second_idx", 32'(out_idx), 32'd2);
        tick();
        chk("rr_third_valid", 32'(out_valid), 32'd1);
        chk("rr_third_idx", 32'(out_idx), 32'd7);
        tick();
        chk("rr_done", 32'(out_valid), 32'd0);

        // held snapshot stays while entry is rewritten, newer value exported after
        out_ready = 1'b0;
        wr_a(4'd5, 8'hFF, 8'h55);
        exp_q.push_back('{4'd5, 8'h55});
        tick(); idle_ports();
        tick();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_idx", 32'(out_idx), 32'd5);
        wr_a(4'd5, 8'hFF, 8'h99);
        exp_q.push_back('{4'd5, 8'h99});
        for (int k = 0; k < 4; k++) begin
            tick(); idle_ports();
            chk("hold_stable_val", 32'(out_value), 32'h55);
            chk("hold_stable_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("reexport_valid", 32'(out_valid), 32'd1);
        chk("reexport_val", 32'(out_value), 32'h99);
        tick();
        chk("reexport_done", 32'(out_valid), 32'd0);

        // rewrite identical data
        wr_a(4'd5, 8'hFF, 8'h99);
`ifndef DP_REGFILE_CHANGE_ONLY_EN
        exp_q.push_back('{4'd5, 8'h99});
`endif
        tick(); idle_ports();
        tick();
`ifdef DP_REGFILE_CHANGE_ONLY_EN
        chk("same_data_valid", 32'(out_valid), 32'd0);
`else
        chk("same_data_valid", 32'(out_valid), 32'd1);
`endif
        tick(); tick();
        chk("same_data_done", 32'(out_valid), 32'd0);

        // reset during HOLD drops the pending export
        out_ready = 1'b0;
        wr_a(4'd9, 8'hFF, 8'h44);
        tick(); idle_ports();
        tick();
        chk("pre_reset_hold", 32'(out_valid), 32'd1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        chk("reset_hold_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        rd_idx = 4'd9;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_reset_no_export", 32'(out_valid), 32'd0);
        end
        chk("post_reset_rd", 32'(rd_data), 32'hA4);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_regfile.md
Name: dp_regfile

Overview:
- Single-clock, multi-entry, dual-writer register file. Generalises the single masked-write register to NREGS entries.
- Two independent masked write ports (A and B) with per-bit merge and fixed B-over-A priority.
- One registered read port.
- A change-export stream pushes (index, value) of modified entries to a consumer over a valid/ready handshake. Used for config/status mirroring between subsystems.

Parameters:
- WIDTH, 8, bits per entry
- NREGS, 16, number of entries (>=2)
- RESET_VALUE, 0, per-entry reset value (same for all entries)
- RESET_MASK, '1, bits loaded from RESET_VALUE on reset; unmasked bits keep their value

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous reset, active-low
- a_idx  in  $clog2(NREGS)  port A entry index
- a_mask  in  WIDTH  port A bit write-enable; all-zero = no write
- a_data  in  WIDTH  port A write data
- b_idx  in  $clog2(NREGS)  port B entry index
- b_mask  in  WIDTH  port B bit write-enable
- b_data  in  WIDTH  port B write data
- rd_idx  in  $clog2(NREGS)  read index
- rd_data  out  WIDTH  registered read data
- out_valid  out  1  export entry available
- out_ready  in  1  consumer accepts
- out_idx  out  $clog2(NREGS)  exported entry index
- out_value  out  WIDTH  exported entry value snapshot

Behaviour:
- Storage power-up value 0.
- On reset (nrst=0 at posedge):
  - every entry becomes (RESET_VALUE & RESET_MASK) | (entry & ~RESET_MASK)
  - all dirty flags cleared; out_valid=0; rd_data=0; scan pointer=0
  - writes in the same cycle are ignored
- Write merge per posedge, per entry e:
  - new = (A bits where a_idx==e & a_mask) then B overlaid where b_idx==e & b_mask
  - same-entry overlapping bits: B wins; non-overlapping bits from both apply
- Write latency 1: the value is visible to rd_data/export from the next cycle.
- Read: rd_data <= entry[rd_idx] each cycle (pre-write value; no write-through bypass).
- Dirty flags:
  - dirty[e] set by any write to e with a nonzero effective mask
  - set takes priority over a same-cycle clear
- Export FSM, states IDLE and HOLD:
  - IDLE: if any dirty, select the first dirty index at or after the scan pointer (round-robin, wrap NREGS-1 -> 0). Register out_idx and out_value = current entry value. Clear dirty[sel]. Advance pointer to sel+1 mod NREGS. Go to HOLD with out_valid=1.
  - HOLD: out_idx/out_value stable while out_ready=0. On out_valid&out_ready: if another entry is dirty, select it in the same cycle (back-to-back, one transfer per cycle); else go to IDLE with out_valid=0.
  - A write to an entry already in HOLD re-sets its dirty flag, so the newer value is exported later. A held snapshot is never updated.
- Latency: write at edge t -> dirty at t+1 -> out_valid at t+2 when idle.
- Reset mid-HOLD drops the pending export.
- Index >= NREGS (non-power-of-2 NREGS): write ignored; read returns 0.

Optional Feature:
- Macro DP_REGFILE_CHANGE_ONLY_EN.
- Defined: dirty set only if the merged value differs from the stored value. Writing identical data produces no export.
- Undefined: any nonzero-mask write marks dirty, even if the data is unchanged.

Decomposition:
- Package dp_regfile_pkg:
  - function merge(old, data, mask) = (data & mask) | (old & ~mask)
  - export FSM state enum (IDLE, HOLD)
- Sub-module rr_pick: combinational round-robin first-set finder, inputs (req vector NREGS, start pointer), outputs (found, index). Used by the export FSM.

Test Plan:
- Reset with RESET_VALUE=8'hA5, RESET_MASK=8'hF0 on an entry holding 8'h3C -> entry reads 8'hAC; out_valid=0.
- A writes idx3 mask FF data 11 and B writes idx3 mask 0F data 22 in the same cycle -> entry3=8'h12; single export (3, 8'h12) at t+2.
- Writes to idx 14, 2, 7 with out_ready=1, pointer at 8 -> exports in order 14, 2, 7, back-to-back, one per cycle.
- HOLD on idx5 with out_ready=0 for 4 cycles while idx5 is rewritten to 8'h99 -> out_value stays old; after accept, second export (5, 8'h99).
- With DP_REGFILE_CHANGE_ONLY_EN, rewrite an entry with the same data -> no out_valid. Without the macro -> one export.
- nrst low during HOLD -> out_valid=0 next cycle; dirty cleared; no export after reset release.
